// File: rtl/fetch_queue.sv
// Fetch queue between the fetch and decode stages. Holds up to DEPTH
// {pc, instr} entries in a circular buffer, pre-decodes J-type jumps on the
// push side and redirects fetch, then drops the one delay-slot word that
// fetch delivers after the jump was seen.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [29:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  output logic [29:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready,
  input  logic        flush,
  output logic        jump_en,
  output logic [29:0] jump_addr,
  output logic [3:0]  count
);

  localparam int          PTR_W    = $clog2(DEPTH);
  localparam logic [3:0]  FULL_CNT = 4'(DEPTH);
  localparam logic [5:0]  OP_J     = 6'b000010;

  typedef enum logic {
    IDLE,
    SQUASH
  } state_e;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [3:0]         count_q, count_d;
  state_e             state_q;

  logic squash;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic is_jump;
  entry_t head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake, pre-decode and head presentation.
  assign squash  = (state_q == SQUASH);
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == 4'd0);
  assign is_jump = (in_instr[31:26] == OP_J);

  // The squashed word is swallowed, so fetch always sees ready while squashing.
  assign in_ready  = squash | ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & ~full & ~flush & ~squash & ~reset;
  assign pop       = ~empty & out_ready & ~flush;

  assign jump_en   = push & is_jump;
  assign jump_addr = jump_en ? {in_pc[29:28], in_instr[25:0], 2'b00} : '0;

  assign head      = mem_q[rd_ptr_q];
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : '0;
  assign count     = count_q;

  // Next pointer and occupancy values; flush returns the queue to empty.
  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = 4'd0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (push && !pop)      count_d = count_q + 4'd1;
      else if (pop && !push) count_d = count_q - 4'd1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written at the tail on each accepted push.
  // NOTE: the array has no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
  end

  // Squash FSM: arm on a pre-decoded jump, disarm after dropping one word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (jump_en)  state_q <= SQUASH;
        SQUASH:  if (in_valid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (DEPTH=4): a queue-based reference
// model is compared with every DUT output once per cycle, directed scenarios
// add literal expectations, then randomized traffic runs against the model.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NJ    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [29:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [29:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        flush;
  logic        jump_en;
  logic [29:0] jump_addr;
  logic [3:0]  count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .flush     (flush),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .count     (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of {pc, instr} plus a "drop next word" flag.
  logic [61:0] mq[$];
  bit          m_sq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_jump();
    return in_valid && !flush && !m_sq && (mq.size() < DEPTH) && (in_instr[31:26] == 6'd2);
  endfunction

  task automatic compare_model();
    bit          jv;
    logic [29:0] ja;
    jv = m_jump();
    ja = jv ? {in_pc[29:28], in_instr[25:0], 2'b00} : 30'd0;
    check("count",     64'(count),     64'(mq.size()));
    check("in_ready",  64'(in_ready),  64'(m_sq || mq.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("out_pc",    64'(out_pc),    (mq.size() != 0) ? 64'(mq[0][61:32]) : 64'd0);
    check("out_instr", 64'(out_instr), (mq.size() != 0) ? 64'(mq[0][31:0])  : 64'd0);
    check("jump_en",   64'(jump_en),   64'(jv));
    check("jump_addr", 64'(jump_addr), 64'(ja));
  endtask

  // Drive one cycle's inputs mid-cycle and compare before the rising edge.
  task automatic drive(input bit v, input logic [29:0] pc, input logic [31:0] ins,
                       input bit ordy, input bit fl);
    @(negedge clk);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    #1;
    compare_model();
  endtask

  // Advance through the rising edge and apply the same inputs to the model.
  task automatic tick();
    bit jv, do_push, do_pop;
    jv = m_jump();
    @(posedge clk);
    if (flush) begin
      mq.delete();
      m_sq = 1'b0;
    end else begin
      do_push = in_valid && !m_sq && (mq.size() < DEPTH);
      do_pop  = out_ready && (mq.size() != 0);
      if (m_sq && in_valid) m_sq = 1'b0;
      else if (jv)          m_sq = 1'b1;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({in_pc, in_instr});
    end
  endtask

  task automatic step(input bit v, input logic [29:0] pc, input logic [31:0] ins,
                      input bit ordy, input bit fl);
    drive(v, pc, ins, ordy, fl);
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_pc = 30'h100; in_instr = 32'h0800_0040;
    out_ready = 1'b1; flush = 1'b0;
    m_sq = 1'b0;

    // Reset values, with a jump word presented to prove jump_en stays low.
    #3;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_jump_en", 64'(jump_en), 64'd0);
    check("rst_jump_addr", 64'(jump_addr), 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Fill to DEPTH with decode stalled.
    step(1, 30'd0,  NJ | 32'h100, 0, 0);
    step(1, 30'd4,  NJ | 32'h200, 0, 0);
    step(1, 30'd8,  NJ | 32'h300, 0, 0);
    step(1, 30'd12, NJ | 32'h400, 0, 0);
    drive(1, 30'd20, NJ, 0, 0);
    check("fill_count", 64'(count), 64'd4);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_head", 64'(out_pc), 64'd0);
    tick();
    drive(0, 30'd0, NJ, 0, 0);
    check("fill_fifth_dropped", 64'(count), 64'd4);
    tick();

    // Drain with wrap: pc 16 enters behind the original four.
    drive(0, 30'd0, NJ, 1, 0);  check("drain0", 64'(out_pc), 64'd0);  tick();
    drive(1, 30'd16, NJ, 1, 0); check("drain1", 64'(out_pc), 64'd4);  tick();
    drive(0, 30'd0, NJ, 1, 0);  check("drain2", 64'(out_pc), 64'd8);  tick();
    drive(0, 30'd0, NJ, 1, 0);  check("drain3", 64'(out_pc), 64'd12); tick();
    drive(0, 30'd0, NJ, 1, 0);  check("drain4", 64'(out_pc), 64'd16); tick();
    drive(0, 30'd0, NJ, 0, 0);  check("drain_empty", 64'(out_valid), 64'd0); tick();

    // Jump pre-decode and delay-slot squash.
    drive(1, 30'h100, 32'h0800_0040, 0, 0);
    check("jmp_en", 64'(jump_en), 64'd1);
    check("jmp_addr", 64'(jump_addr), 64'h100);
    tick();
    drive(0, 30'h0, NJ, 0, 0);
    check("sq_wait_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1, 30'h104, 32'h0800_0099, 0, 0);
    check("sq_drop_no_jump", 64'(jump_en), 64'd0);
    tick();
    step(1, 30'h108, NJ, 0, 0);
    drive(0, 30'h0, NJ, 0, 0);
    check("jmp_count", 64'(count), 64'd2);
    check("jmp_head", 64'(out_pc), 64'h100);
    tick();

    // Simultaneous push and pop at count 2.
    step(1, 30'h10c, NJ, 1, 0);
    drive(0, 30'h0, NJ, 0, 0);
    check("sim_count", 64'(count), 64'd2);
    check("sim_head", 64'(out_pc), 64'h108);
    tick();

    // Flush with 3 entries while push and pop are requested.
    step(1, 30'h110, NJ, 0, 0);
    drive(1, 30'h114, 32'h0800_0040, 1, 1);
    check("flush_jump_en", 64'(jump_en), 64'd0);
    tick();
    drive(0, 30'h0, NJ, 0, 0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    tick();

    // Asynchronous reset with 3 entries and squash armed.
    step(1, 30'h200, NJ, 0, 0);
    step(1, 30'h204, NJ, 0, 0);
    step(1, 30'h208, 32'h0800_0123, 0, 0);
    #2;
    in_valid = 1'b1; in_instr = 32'h0800_0040; out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_pc", 64'(out_pc), 64'd0);
    check("arst_out_instr", 64'(out_instr), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_jump_en", 64'(jump_en), 64'd0);
    mq.delete();
    m_sq = 1'b0;
    #1;
    reset = 1'b0;
    // Squash must be cleared: this word is stored.
    step(1, 30'h300, NJ, 0, 0);
    drive(0, 30'h0, NJ, 0, 0);
    check("arst_sq_cleared", 64'(count), 64'd1);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      ins = $urandom();
      if ($urandom_range(0, 4) == 0) ins[31:26] = 6'b000010;
      else if (ins[31:26] == 6'b000010) ins[31:26] = 6'b000000;
      step(($urandom_range(0, 9) < 7), 30'($urandom()), ins,
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
